gen_reg_wb_queue: RTL

Writeback queue sitting directly upstream of the six-entry general register file. Accepts register write requests from the execute/memory stages over a valid/ready handshake, buffers them in a small in-order FIFO, and retires at most one write per cycle onto the register file's write port (address, half-word select, 20-bit data). Optionally exposes a forwarding lookup so decode can read a pending full-word value before it lands in the register file.

---
 rtl/gen_reg_wb_queue_if.sv | 27 ++
 rtl/gen_reg_wb_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gen_reg_wb_queue_if.sv
// Bus bundle between the execute/memory stages, the writeback queue and the register-file write port.
// Handshakes: in_* completes on a rising edge with in_valid && in_ready; wr_* retires on a rising edge with wr_en && !wr_stall.
interface gen_reg_wb_queue_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_reg;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              wr_stall;

    modport master (
        output in_valid, in_reg, in_sel, in_data, wr_stall,
        input  in_ready, wr_en, wr_addr, wr_sel, wr_data
    );

    modport slave (
        input  in_valid, in_reg, in_sel, in_data, wr_stall,
        output in_ready, wr_en, wr_addr, wr_sel, wr_data
    );
endinterface

// File: rtl/gen_reg_wb_queue.sv
// In-order writeback FIFO in front of the general register file, with flush/drain FSM.
// Define GEN_REG_WB_FWD_EN to build the youngest-first forwarding lookup; otherwise lk_* outputs are 0.
module gen_reg_wb_queue #(
    parameter int DATA_W = 20,
    parameter int NREG   = 6,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    gen_reg_wb_queue_if.slave bus,
    input  logic              flush,
    output logic              flush_done,
    output logic              err,
    output logic [2:0]        count,
    input  logic [2:0]        lk_reg,
    output logic              lk_hit,
    output logic              lk_partial,
    output logic [DATA_W-1:0] lk_data,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [2:0] NREG_C  = 3'(NREG);

    logic [2:0]        reg_q  [DEPTH];
    logic [1:0]        sel_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       state;
    logic             err_q;

    logic push;
    logic legal;
    logic enq;
    logic pop;
    logic nonempty;

    assign nonempty     = (count != 3'd0);
    assign bus.in_ready = (count < DEPTH_C) && (state == ST_RUN);
    assign push         = bus.in_valid && bus.in_ready;
    assign legal        = (bus.in_reg < NREG_C) && (bus.in_sel != 2'b11);
    assign enq          = push && legal;
    assign pop          = nonempty && !bus.wr_stall;

    // Head fields are only exposed while something is queued, so an empty queue drives zeros.
    assign bus.wr_en   = nonempty;
    assign bus.wr_addr = nonempty ? {{(ADDR_W-3){1'b0}}, reg_q[rd_ptr]} : '0;
    assign bus.wr_sel  = nonempty ? sel_q[rd_ptr] : 2'b00;
    assign bus.wr_data = nonempty ? data_q[rd_ptr] : '0;

    assign err        = err_q;
    assign flush_done = (state == ST_DONE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (enq) begin
            reg_q[wr_ptr]  <= bus.in_reg;
            sel_q[wr_ptr]  <= bus.in_sel;
            data_q[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= push && !legal;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !pop)      count <= count + 3'd1;
            else if (!enq && pop) count <= count - 3'd1;
        end
    end

    // A flush seen in DRAIN or DONE is ignored; DRAIN checks emptiness in the current cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush) state <= ST_DRAIN;
                ST_DRAIN: if (!nonempty) state <= ST_DONE;
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

`ifdef GEN_REG_WB_FWD_EN
    logic [PTR_W-1:0] lk_idx;

    // Walk oldest to youngest so the youngest matching entry is the last one written.
    always_comb begin
        lk_hit     = 1'b0;
        lk_partial = 1'b0;
        lk_data    = '0;
        lk_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = rd_ptr + PTR_W'(k);
            if ((3'(k) < count) && (reg_q[lk_idx] == lk_reg)) begin
                lk_hit     = (sel_q[lk_idx] == 2'b00);
                lk_partial = (sel_q[lk_idx] != 2'b00);
                lk_data    = (sel_q[lk_idx] == 2'b00) ? data_q[lk_idx] : '0;
            end
        end
    end
`else
    logic unused_lk;
    assign unused_lk  = ^lk_reg;
    assign lk_hit     = 1'b0;
    assign lk_partial = 1'b0;
    assign lk_data    = '0;
`endif
endmodule
